aclk_keyentry: RTL and testbench
================================

# aclk_keyentry

Keypad digit-entry controller for the alarm clock. It collects four decimal key presses into an HH:MM buffer and validates the value as a 24-hour time. On an ALARM or TIME command key it issues a one-cycle load strobe, together with the buffered digits, to the alarm register or to the time-of-day counter. It sits between the key scanner/decoder and the alarm/time storage blocks, and is the writer side of their `load_new_*` / `new_*` digit interface.

## Interface
- `TIMEOUT_SECS`, default 10: number of `one_second` strobes without a key press after which an entry in progress is abandoned. Legal range is 1 to 255.

- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `one_second`  input  1  one-cycle-wide strobe, once per second
- `key_valid`  input  1  one-cycle strobe: `key` holds a new press
- `key`  input  4  key code: 0–9 are digits, 10 is ALARM, 11 is TIME, 12–15 are ignored
- `new_alarm_ms_hr`  output  4  buffered hour tens digit
- `new_alarm_ls_hr`  output  4  buffered hour units digit
- `new_alarm_ms_min`  output  4  buffered minute tens digit
- `new_alarm_ls_min`  output  4  buffered minute units digit
- `load_new_a`  output  1  one-cycle strobe: load the buffer as the alarm time
- `load_new_c`  output  1  one-cycle strobe: load the buffer as the clock time
- `entry_active`  output  1  high while in state ENTRY
- `entry_error`  output  1  one-cycle strobe: command rejected

## Operation
- All outputs are registered.
- Reset (`reset`=0, takes effect immediately): state IDLE, all four digits 0, digit count 0, timer 0, all strobes 0, `entry_active`=0.
- States: IDLE and ENTRY. `entry_active` equals (state==ENTRY).
- **Digit shift** (key 0–9 with `key_valid`):
  - ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←key.
  - Count increments and saturates at 4.
  - Timer clears to 0.
- **IDLE:**
  - Digit key: clear all four digits, then shift in the key (result is 0,0,0,key). Set count=1 and go to ENTRY.
  - Keys 10–15: ignored, no strobe.
- **ENTRY:**
  - Digit key: shift as above. More than four digits keeps the last four.
  - ALARM or TIME key with count==4 and the buffer valid: pulse `load_new_a` or `load_new_c` respectively. Go to IDLE. Buffer is kept unchanged.
  - ALARM or TIME key with count<4 or the buffer invalid: pulse `entry_error`, no load strobe. Go to IDLE. Buffer is kept unchanged.
  - Keys 12–15: ignored. The timer is not cleared.
  - `one_second` with no simultaneous `key_valid`: timer increments. When the timer reaches `TIMEOUT_SECS`: go to IDLE, clear all digits to 0, clear count, no strobe.
- **Validity rule:**
  - ms_hr ≤ 2.
  - ms_hr==2 requires ls_hr ≤ 3.
  - ms_min ≤ 5.
  - Digits above 9 cannot occur, because only keys 0–9 shift in.
- **Simultaneous events:**
  - `key_valid` and `one_second` in the same cycle: the key is processed, the timer clears, and the strobe is ignored.
  - `load_new_a`, `load_new_c` and `entry_error` are mutually exclusive.
- Timer width is the smallest that holds `TIMEOUT_SECS`, 8 bits maximum. The timer only counts in ENTRY and is held at 0 in IDLE.

## Timing
- The key is sampled at edge N. State, digits and count update at edge N, so they are visible in cycle N+1.
- A load or error strobe is high for exactly cycle N+1, then returns to 0 at edge N+2.
- Digit outputs are stable for the whole strobe cycle and after it until the next digit key or timeout. The receiving register can therefore sample them on the strobe.
- Back-to-back `key_valid` on consecutive cycles must be accepted. Each press is processed in its own cycle.
- A command key in ENTRY followed by a digit key in the very next cycle: the strobe occurs in cycle N+1, and that digit starts a new entry from IDLE, clearing the buffer.
- Timeout: the `TIMEOUT_SECS`-th `one_second` strobe after the last key, sampled at edge M. `entry_active` falls and the digits are 0 from cycle M+1.
- `reset` asserted mid-entry or during a strobe: all outputs go to reset values asynchronously. The first accepted key is the first `key_valid` sampled after `reset` deasserts.

## Test plan
- **Alarm load:** after reset, keys 0,7,3,0 then ALARM. Required: `load_new_a`=1 for one cycle with digits 0,7,3,0; `entry_active`=0 afterwards; `load_new_c` never asserts.
- **Invalid hour and short entry:**
  - Keys 2,4,0,0 then TIME. Required: `entry_error` pulses once, no load strobe, digits stay 2,4,0,0.
  - Keys 1,5 then ALARM. Required: `entry_error` pulses once.
- **Overflow entry:** keys 1,2,3,4,5 then TIME. Required: `load_new_c` pulses once with digits 2,3,4,5.
- **Timeout with `TIMEOUT_SECS`=3:**
  - Key 9, then three `one_second` strobes. Required: `entry_active` falls the cycle after the 3rd strobe, digits 0,0,0,0, no strobe.
  - Repeat with a key press arriving in the same cycle as the 3rd strobe. Required: no timeout; the digit shifts in.
- **Reset mid-entry:** keys 1,8 then drive `reset` low between clock edges. Required: `entry_active`=0, digits 0 and strobes 0 immediately. After release, ALARM alone produces nothing, and a full 1,8,4,5,ALARM loads 1,8,4,5.
- **Ignored keys:** in IDLE, ALARM, TIME and codes 12–15 produce no outputs. In ENTRY, code 14 neither shifts the buffer nor resets the timeout.

Source files
------------

// File: rtl/aclk_keyentry.sv
// Keypad HH:MM entry controller: shifts in four digits, validates a 24-hour time
// and strobes the buffer into the alarm register or the time-of-day counter.
module aclk_keyentry #(
  parameter int TIMEOUT_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       entry_active,
  output logic       entry_error
);

  localparam int TW = (TIMEOUT_SECS < 2) ? 1 : $clog2(TIMEOUT_SECS + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_SECS);

  localparam logic [3:0] KEY_ALARM = 4'd10;
  localparam logic [3:0] KEY_TIME  = 4'd11;

  typedef enum logic {IDLE, ENTRY} state_t;

  state_t          state_q, state_d;
  // dig[3]=ms_hr, dig[2]=ls_hr, dig[1]=ms_min, dig[0]=ls_min
  logic [3:0][3:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            la_q, la_d, lc_q, lc_d, err_q, err_d;

  logic          is_digit, is_cmd, buf_ok;
  logic [TW-1:0] tmr_inc;

  assign is_digit = (key < 4'd10);
  assign is_cmd   = (key == KEY_ALARM) || (key == KEY_TIME);
  assign tmr_inc  = tmr_q + 1'b1;
  assign buf_ok   = (dig_q[3] <= 4'd2) &&
                    ((dig_q[3] != 4'd2) || (dig_q[2] <= 4'd3)) &&
                    (dig_q[1] <= 4'd5);

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    la_d    = 1'b0;
    lc_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (key_valid && is_digit) begin
          dig_d   = {12'h000, key};
          cnt_d   = 3'd1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (key_valid) begin
          // Ignored codes leave the timer alone and also swallow a coincident one_second.
          if (is_digit) begin
            dig_d = {dig_q[2:0], key};
            cnt_d = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
            tmr_d = '0;
          end else if (is_cmd) begin
            state_d = IDLE;
            tmr_d   = '0;
            if (cnt_q == 3'd4 && buf_ok) begin
              la_d = (key == KEY_ALARM);
              lc_d = (key == KEY_TIME);
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (one_second) begin
          if (tmr_inc == TMO) begin
            state_d = IDLE;
            dig_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dig_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      la_q    <= 1'b0;
      lc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      la_q    <= la_d;
      lc_q    <= lc_d;
      err_q   <= err_d;
    end
  end

  assign new_alarm_ms_hr  = dig_q[3];
  assign new_alarm_ls_hr  = dig_q[2];
  assign new_alarm_ms_min = dig_q[1];
  assign new_alarm_ls_min = dig_q[0];
  assign load_new_a       = la_q;
  assign load_new_c       = lc_q;
  assign entry_active     = (state_q == ENTRY);
  assign entry_error      = err_q;

endmodule

// File: tb/tb_aclk_keyentry.sv
// Directed vector bench for aclk_keyentry with TIMEOUT_SECS=3.
module tb_aclk_keyentry;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second, key_valid;
  logic [3:0] key;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       la, lc, act, err;

  aclk_keyentry #(.TIMEOUT_SECS(3)) dut (
    .clk(clk), .reset(reset), .one_second(one_second),
    .key_valid(key_valid), .key(key),
    .new_alarm_ms_hr(ms_hr), .new_alarm_ls_hr(ls_hr),
    .new_alarm_ms_min(ms_min), .new_alarm_ls_min(ls_min),
    .load_new_a(la), .load_new_c(lc), .entry_active(act), .entry_error(err)
  );

  always #5 clk = ~clk;

  // flags = {load_new_a, load_new_c, entry_active, entry_error}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_LA   = 4'b1000;
  localparam logic [3:0] F_LC   = 4'b0100;
  localparam logic [3:0] F_ACT  = 4'b0010;
  localparam logic [3:0] F_ERR  = 4'b0001;

  typedef struct {
    logic        kv;
    logic [3:0]  key;
    logic        os;
    logic [15:0] dig;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic kv, input logic [3:0] k, input logic os,
                     input logic [15:0] d, input logic [3:0] f);
    vecs.push_back('{kv, k, os, d, f});
  endtask

  task automatic check(input string name, input logic [15:0] d, input logic [3:0] f);
    logic [19:0] got, exp;
    got = {ms_hr, ls_hr, ms_min, ls_min, la, lc, act, err};
    exp = {d, f};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got dig=%h flags=%b, expected dig=%h flags=%b",
               name, got[19:4], got[3:0], exp[19:4], exp[3:0]);
    end
  endtask

  task automatic step(input string name, input logic kv, input logic [3:0] k,
                      input logic os, input logic [15:0] d, input logic [3:0] f);
    @(negedge clk);
    key_valid  = kv;
    key        = k;
    one_second = os;
    @(posedge clk);
    #1;
    check(name, d, f);
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key = '0; one_second = 1'b0;
    #1;
    check("reset_state", 16'h0000, F_NONE);

    // alarm load 07:30
    add(1, 0, 0, 16'h0000, F_ACT);
    add(1, 7, 0, 16'h0007, F_ACT);
    add(1, 3, 0, 16'h0073, F_ACT);
    add(1, 0, 0, 16'h0730, F_ACT);
    add(1, 10, 0, 16'h0730, F_LA);
    add(0, 0, 0, 16'h0730, F_NONE);
    // invalid hour 24:00 with TIME
    add(1, 2, 0, 16'h0002, F_ACT);
    add(1, 4, 0, 16'h0024, F_ACT);
    add(1, 0, 0, 16'h0240, F_ACT);
    add(1, 0, 0, 16'h2400, F_ACT);
    add(1, 11, 0, 16'h2400, F_ERR);
    add(0, 0, 0, 16'h2400, F_NONE);
    // short entry
    add(1, 1, 0, 16'h0001, F_ACT);
    add(1, 5, 0, 16'h0015, F_ACT);
    add(1, 10, 0, 16'h0015, F_ERR);
    // overflow entry, then a digit right after the command
    add(1, 1, 0, 16'h0001, F_ACT);
    add(1, 2, 0, 16'h0012, F_ACT);
    add(1, 3, 0, 16'h0123, F_ACT);
    add(1, 4, 0, 16'h1234, F_ACT);
    add(1, 5, 0, 16'h2345, F_ACT);
    add(1, 11, 0, 16'h2345, F_LC);
    add(1, 6, 0, 16'h0006, F_ACT);
    // code 14 in ENTRY must not restart the timeout
    add(0, 0, 1, 16'h0006, F_ACT);
    add(0, 0, 1, 16'h0006, F_ACT);
    add(1, 14, 0, 16'h0006, F_ACT);
    add(0, 0, 1, 16'h0000, F_NONE);
    // plain timeout
    add(1, 9, 0, 16'h0009, F_ACT);
    add(0, 0, 1, 16'h0009, F_ACT);
    add(0, 0, 1, 16'h0009, F_ACT);
    add(0, 0, 1, 16'h0000, F_NONE);
    // key coincident with the 3rd strobe wins
    add(1, 9, 0, 16'h0009, F_ACT);
    add(0, 0, 1, 16'h0009, F_ACT);
    add(0, 0, 1, 16'h0009, F_ACT);
    add(1, 1, 1, 16'h0091, F_ACT);
    add(0, 0, 1, 16'h0091, F_ACT);
    add(0, 0, 1, 16'h0091, F_ACT);
    add(0, 0, 1, 16'h0000, F_NONE);
    // ignored codes in IDLE
    add(1, 10, 0, 16'h0000, F_NONE);
    add(1, 11, 0, 16'h0000, F_NONE);
    add(1, 12, 0, 16'h0000, F_NONE);
    add(1, 15, 0, 16'h0000, F_NONE);
    add(0, 0, 1, 16'h0000, F_NONE);
    // boundary: 23:59 is valid, 19:60 is not
    add(1, 2, 0, 16'h0002, F_ACT);
    add(1, 3, 0, 16'h0023, F_ACT);
    add(1, 5, 0, 16'h0235, F_ACT);
    add(1, 9, 0, 16'h2359, F_ACT);
    add(1, 10, 0, 16'h2359, F_LA);
    add(1, 1, 0, 16'h0001, F_ACT);
    add(1, 9, 0, 16'h0019, F_ACT);
    add(1, 6, 0, 16'h0196, F_ACT);
    add(1, 0, 0, 16'h1960, F_ACT);
    add(1, 11, 0, 16'h1960, F_ERR);
    add(0, 0, 0, 16'h1960, F_NONE);

    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].kv, vecs[i].key, vecs[i].os,
           vecs[i].dig, vecs[i].flg);

    // reset asserted between edges during an entry
    step("rst_k1", 1, 1, 0, 16'h0001, F_ACT);
    step("rst_k8", 1, 8, 0, 16'h0018, F_ACT);
    @(negedge clk);
    key_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_async", 16'h0000, F_NONE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    step("rst_alarm_only", 1, 10, 0, 16'h0000, F_NONE);
    step("rst_e1", 1, 1, 0, 16'h0001, F_ACT);
    step("rst_e8", 1, 8, 0, 16'h0018, F_ACT);
    step("rst_e4", 1, 4, 0, 16'h0184, F_ACT);
    step("rst_e5", 1, 5, 0, 16'h1845, F_ACT);
    step("rst_load", 1, 10, 0, 16'h1845, F_LA);
    step("rst_after", 0, 0, 0, 16'h1845, F_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
